// File: rtl/wb_serial_master_pkg.sv
// Shared definitions for the byte-command Wishbone initiator: FSM state
// encoding, command/response byte values and byte-counter terminal counts.
package wb_serial_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_BUS  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    // Command opcodes received on the serial side
    localparam logic [7:0] CMD_WRITE   = 8'h57;  // 'W'
    localparam logic [7:0] CMD_READ    = 8'h52;  // 'R'

    // Response bytes sent back on the serial side
    localparam logic [7:0] RSP_OK      = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_TIMEOUT = 8'h45;  // 'E'
    localparam logic [7:0] RSP_UNKNOWN = 8'h3F;  // '?'

    // Terminal values of the 2-bit address/data byte counter
    localparam logic [1:0] ADDR_LAST   = 2'd3;
    localparam logic [1:0] DATA_LAST   = 2'd1;

endpackage

// File: rtl/wb_serial_master_txq.sv
// Response byte sequencer: holds up to two bytes and hands them to the
// serial transmitter one at a time, only while the transmitter is idle and
// never in two consecutive cycles, so the transmitter has a cycle to raise
// its busy flag after each strobe.
module wb_serial_txq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] byte0,
    input  logic [7:0] byte1,
    input  logic [1:0] count,
    input  logic       tx_busy,
    output logic [7:0] tx_dat,
    output logic       tx_stb,
    output logic       empty
);

    logic [7:0] head_reg;
    logic [7:0] tail_reg;
    logic [1:0] pending_reg;
    logic       gap_reg;
    logic       fire;

    // The strobe is qualified by the live busy input so that it can never
    // appear in a cycle where the transmitter reports busy.
    assign fire   = (pending_reg != 2'd0) && !tx_busy && !gap_reg;
    assign tx_stb = fire;
    assign tx_dat = head_reg;
    assign empty  = (pending_reg == 2'd0);

    // Load a new response, or shift out the head byte when it is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_reg    <= 8'h00;
            tail_reg    <= 8'h00;
            pending_reg <= 2'd0;
            gap_reg     <= 1'b0;
        end else if (load) begin
            head_reg    <= byte0;
            tail_reg    <= byte1;
            pending_reg <= count;
            gap_reg     <= 1'b0;
        end else if (fire) begin
            head_reg    <= tail_reg;
            pending_reg <= pending_reg - 2'd1;
            gap_reg     <= 1'b1;
        end else begin
            gap_reg     <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_serial_master.sv
// Wishbone initiator driven by a serial byte command stream.
//   'W' a3 a2 a1 a0 d1 d0 : 16-bit write, answered with 'K'
//   'R' a3 a2 a1 a0       : 16-bit read, answered with data[15:8], data[7:0]
//   anything else in IDLE : answered with '?'
// Optional build macro WB_SERIAL_MASTER_TIMEOUT_EN adds an ack timeout of
// TIMEOUT_CYCLES strobed cycles, answered with 'E'; without it a bus cycle
// waits for ack forever.
module wb_serial_master
    import wb_serial_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_dat_i,
    input  logic        rx_stb_i,
    output logic [7:0]  tx_dat_o,
    output logic        tx_stb_o,
    input  logic        tx_busy_i,
    output logic [31:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    output logic [1:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        busy_o
);

    state_t      state_reg;
    logic [1:0]  byte_cnt_reg;
    logic        is_write_reg;
    logic [31:0] addr_reg;
    logic [15:0] data_reg;
    logic        cyc_reg;
    logic        stb_reg;
    logic        we_reg;
    logic [1:0]  sel_reg;
    logic [7:0]  resp0_reg;
    logic [7:0]  resp1_reg;
    logic [1:0]  resp_cnt_reg;
    logic        load_reg;
    logic        txq_empty;
    logic        tmo_hit;

    assign wb_adr_o = {addr_reg[31:1], 1'b0};
    assign wb_dat_o = data_reg;
    assign wb_sel_o = sel_reg;
    assign wb_we_o  = we_reg;
    assign wb_cyc_o = cyc_reg;
    assign wb_stb_o = stb_reg;
    assign busy_o   = (state_reg != ST_IDLE);

`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt_reg;

    // Count cycles spent with the strobe raised; idle whenever no strobe.
    always_ff @(posedge clk_i) begin
        if (!rst_i || !stb_reg) begin
            tmo_cnt_reg <= 16'd0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
        end
    end

    // Fires in the last permitted strobed cycle if ack has not arrived.
    assign tmo_hit = stb_reg && (tmo_cnt_reg == TMO_LAST);
`else
    // The limit is always at least 2, so this never fires and BUS waits
    // for ack indefinitely.
    assign tmo_hit = (TIMEOUT_CYCLES == 0);
`endif

    // Command parser, Wishbone cycle control and response selection.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg    <= ST_IDLE;
            byte_cnt_reg <= 2'd0;
            is_write_reg <= 1'b0;
            addr_reg     <= 32'h0;
            data_reg     <= 16'h0;
            cyc_reg      <= 1'b0;
            stb_reg      <= 1'b0;
            we_reg       <= 1'b0;
            sel_reg      <= 2'b00;
            resp0_reg    <= 8'h00;
            resp1_reg    <= 8'h00;
            resp_cnt_reg <= 2'd0;
            load_reg     <= 1'b0;
        end else begin
            load_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (rx_stb_i) begin
                        byte_cnt_reg <= 2'd0;
                        if (rx_dat_i == CMD_WRITE) begin
                            is_write_reg <= 1'b1;
                            state_reg    <= ST_ADDR;
                        end else if (rx_dat_i == CMD_READ) begin
                            is_write_reg <= 1'b0;
                            state_reg    <= ST_ADDR;
                        end else begin
                            resp0_reg    <= RSP_UNKNOWN;
                            resp1_reg    <= 8'h00;
                            resp_cnt_reg <= 2'd1;
                            load_reg     <= 1'b1;
                            state_reg    <= ST_RESP;
                        end
                    end
                end

                ST_ADDR: begin
                    if (rx_stb_i) begin
                        // Big-endian: first byte ends up in bits 31:24
                        addr_reg <= {addr_reg[23:0], rx_dat_i};
                        if (byte_cnt_reg == ADDR_LAST) begin
                            byte_cnt_reg <= 2'd0;
                            if (is_write_reg) begin
                                state_reg <= ST_DATA;
                            end else begin
                                cyc_reg   <= 1'b1;
                                stb_reg   <= 1'b1;
                                we_reg    <= 1'b0;
                                sel_reg   <= 2'b11;
                                state_reg <= ST_BUS;
                            end
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        end
                    end
                end

                ST_DATA: begin
                    if (rx_stb_i) begin
                        data_reg <= {data_reg[7:0], rx_dat_i};
                        if (byte_cnt_reg == DATA_LAST) begin
                            byte_cnt_reg <= 2'd0;
                            cyc_reg      <= 1'b1;
                            stb_reg      <= 1'b1;
                            we_reg       <= 1'b1;
                            sel_reg      <= 2'b11;
                            state_reg    <= ST_BUS;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        end
                    end
                end

                ST_BUS: begin
                    // cyc is always high here, so ack is only honoured
                    // inside an active cycle; serial input is ignored.
                    if (wb_ack_i) begin
                        cyc_reg  <= 1'b0;
                        stb_reg  <= 1'b0;
                        we_reg   <= 1'b0;
                        sel_reg  <= 2'b00;
                        load_reg <= 1'b1;
                        if (is_write_reg) begin
                            resp0_reg    <= RSP_OK;
                            resp1_reg    <= 8'h00;
                            resp_cnt_reg <= 2'd1;
                        end else begin
                            resp0_reg    <= wb_dat_i[15:8];
                            resp1_reg    <= wb_dat_i[7:0];
                            resp_cnt_reg <= 2'd2;
                        end
                        state_reg <= ST_RESP;
                    end else if (tmo_hit) begin
                        cyc_reg      <= 1'b0;
                        stb_reg      <= 1'b0;
                        we_reg       <= 1'b0;
                        sel_reg      <= 2'b00;
                        load_reg     <= 1'b1;
                        resp0_reg    <= RSP_TIMEOUT;
                        resp1_reg    <= 8'h00;
                        resp_cnt_reg <= 2'd1;
                        state_reg    <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    // load_reg guards the cycle before the queue is filled.
                    if (!load_reg && txq_empty) begin
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    wb_serial_txq u_txq (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .load    (load_reg),
        .byte0   (resp0_reg),
        .byte1   (resp1_reg),
        .count   (resp_cnt_reg),
        .tx_busy (tx_busy_i),
        .tx_dat  (tx_dat_o),
        .tx_stb  (tx_stb_o),
        .empty   (txq_empty)
    );

endmodule

// File: tb/tb_wb_serial_master.sv
// Directed bench for wb_serial_master: write, read with wait states,
// unknown command, ack timeout (or indefinite wait without the timeout
// build), reset in the middle of a bus cycle and a held-off transmitter.
module tb_wb_serial_master;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [7:0]  rx_dat_i;
    logic        rx_stb_i;
    logic [7:0]  tx_dat_o;
    logic        tx_stb_o;
    logic        tx_busy_i;
    logic [31:0] wb_adr_o;
    logic [15:0] wb_dat_o;
    logic [15:0] wb_dat_i;
    logic [1:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        busy_o;

    int compared   = 0;
    int mismatched = 0;

    // Written only by the monitor below
    logic [7:0] tx_log[$];
    int         cyc_cycles = 0;
    int         busy_viol  = 0;
    int         gap_viol   = 0;
    int         ctl_viol   = 0;
    logic       prev_tx    = 1'b0;

    always #5 clk = ~clk;

    wb_serial_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .rx_dat_i  (rx_dat_i),
        .rx_stb_i  (rx_stb_i),
        .tx_dat_o  (tx_dat_o),
        .tx_stb_o  (tx_stb_o),
        .tx_busy_i (tx_busy_i),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_o  (wb_sel_o),
        .wb_we_o   (wb_we_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_ack_i  (wb_ack_i),
        .busy_o    (busy_o)
    );

    // Mid-cycle monitor: logs response bytes and protocol rule breaks.
    always @(negedge clk) begin
        prev_tx <= tx_stb_o;
        if (tx_stb_o) begin
            tx_log.push_back(tx_dat_o);
            if (tx_busy_i) busy_viol <= busy_viol + 1;
            if (prev_tx)   gap_viol  <= gap_viol + 1;
        end
        if (wb_cyc_o) cyc_cycles <= cyc_cycles + 1;
        if ((wb_cyc_o !== wb_stb_o) ||
            (wb_cyc_o && ((wb_sel_o !== 2'b11) || (wb_adr_o[0] !== 1'b0))))
            ctl_viol <= ctl_viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] get_tx(input int idx);
        if (idx < tx_log.size()) return tx_log[idx];
        return 8'hxx;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_dat_i = b;
        rx_stb_i = 1'b1;
        @(negedge clk);
        rx_stb_i = 1'b0;
        rx_dat_i = 8'h00;
    endtask

    // Sends n bytes from seq, most significant byte first.
    task automatic send_seq(input logic [55:0] seq, input int n);
        for (int i = n - 1; i >= 0; i--) send_byte(seq[i*8 +: 8]);
    endtask

    task automatic wait_cyc(input string tag);
        for (int i = 0; i < 100 && !wb_cyc_o; i++) @(negedge clk);
        check(tag, {31'd0, wb_cyc_o}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && busy_o; i++) @(negedge clk);
        check(tag, {31'd0, busy_o}, 32'd0);
    endtask

    task automatic ack_now(input logic [15:0] d);
        wb_dat_i = d;
        wb_ack_i = 1'b1;
        @(negedge clk);
        wb_ack_i = 1'b0;
        wb_dat_i = 16'h0000;
    endtask

    int base;
    int cbase;

    initial begin
        rst_i     = 1'b0;
        rx_dat_i  = 8'h00;
        rx_stb_i  = 1'b0;
        tx_busy_i = 1'b0;
        wb_dat_i  = 16'h0000;
        wb_ack_i  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_wbctl", {27'd0, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 32'd0);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_dat", {16'd0, wb_dat_o}, 32'h0);
        check("rst_tx", {23'd0, tx_stb_o, tx_dat_o}, 32'h0);
        rst_i = 1'b1;
        @(negedge clk);

        // Write 0x30000010 <- 0xBEEF
        base = tx_log.size(); cbase = cyc_cycles;
        send_seq(56'h57300000_10BEEF, 7);
        wait_cyc("wr_cyc");
        check("wr_adr", wb_adr_o, 32'h30000010);
        check("wr_dat", {16'd0, wb_dat_o}, 32'h0000BEEF);
        check("wr_we_sel", {29'd0, wb_we_o, wb_sel_o}, 32'h7);
        ack_now(16'h0000);
        wait_idle("wr_idle");
        check("wr_ntx", tx_log.size() - base, 1);
        check("wr_resp", {24'd0, get_tx(base)}, 32'h4B);
        check("wr_cyclen", cyc_cycles - cbase, 1);
        $display("write 30000010 <= BEEF resp %h", get_tx(base));

        // Read 0x10000002, ack after three wait states with 0x1234
        base = tx_log.size(); cbase = cyc_cycles;
        send_seq(56'h5210000002, 5);
        wait_cyc("rd_cyc");
        check("rd_adr", wb_adr_o, 32'h10000002);
        check("rd_we", {31'd0, wb_we_o}, 32'd0);
        repeat (3) @(negedge clk);
        ack_now(16'h1234);
        wait_idle("rd_idle");
        check("rd_cyclen", cyc_cycles - cbase, 4);
        check("rd_ntx", tx_log.size() - base, 2);
        check("rd_resp", {16'd0, get_tx(base), get_tx(base + 1)}, 32'h1234);
        $display("read 10000002 => %h%h", get_tx(base), get_tx(base + 1));

        // Unknown command byte
        base = tx_log.size(); cbase = cyc_cycles;
        send_byte(8'h41);
        wait_idle("unk_idle");
        check("unk_ntx", tx_log.size() - base, 1);
        check("unk_resp", {24'd0, get_tx(base)}, 32'h3F);
        check("unk_nocyc", cyc_cycles - cbase, 0);
        $display("unknown 41 resp %h", get_tx(base));

        // Read of 0xF0000021 with no ack
        base = tx_log.size(); cbase = cyc_cycles;
        send_seq(56'h52F0000021, 5);
        wait_cyc("tmo_cyc");
        check("tmo_adr", wb_adr_o, 32'hF0000020);
`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
        wait_idle("tmo_idle");
        check("tmo_cyclen", cyc_cycles - cbase, 16);
        check("tmo_ntx", tx_log.size() - base, 1);
        check("tmo_resp", {24'd0, get_tx(base)}, 32'h45);
        $display("read F0000021 timeout resp %h", get_tx(base));
`else
        repeat (40) @(negedge clk);
        check("wait_cyc_held", {30'd0, wb_cyc_o, busy_o}, 32'h3);
        check("wait_ntx", tx_log.size() - base, 0);
        ack_now(16'hA5C3);
        wait_idle("wait_idle");
        check("wait_resp", {16'd0, get_tx(base), get_tx(base + 1)}, 32'hA5C3);
        $display("read F0000021 late ack => %h%h", get_tx(base), get_tx(base + 1));
`endif

        // Reset in the middle of a bus cycle
        base = tx_log.size();
        send_seq(56'h5200000040, 5);
        wait_cyc("rr_cyc");
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        check("rr_drop", {29'd0, wb_cyc_o, wb_stb_o, busy_o}, 32'd0);
        rst_i = 1'b1;
        repeat (5) @(negedge clk);
        check("rr_noresp", tx_log.size() - base, 0);
        ack_now(16'hFFFF);
        @(negedge clk);
        check("stray_ack", {30'd0, wb_cyc_o, busy_o}, 32'd0);
        send_seq(56'h57000001_001234, 7);
        wait_cyc("rr2_cyc");
        check("rr2_adr", wb_adr_o, 32'h00000100);
        check("rr2_dat", {16'd0, wb_dat_o}, 32'h1234);
        ack_now(16'h0000);
        wait_idle("rr2_idle");
        check("rr2_resp", {24'd0, get_tx(base)}, 32'h4B);
        $display("reset mid-cycle, then write 00000100 <= 1234 resp %h", get_tx(base));

        // Transmitter held busy for 50 cycles during a read response;
        // a byte arriving in RESP must be dropped.
        base = tx_log.size();
        tx_busy_i = 1'b1;
        send_seq(56'h5200000008, 5);
        wait_cyc("bz_cyc");
        ack_now(16'hCAFE);
        repeat (5) @(negedge clk);
        send_byte(8'h41);
        repeat (43) @(negedge clk);
        check("bz_held", tx_log.size() - base, 0);
        check("bz_busy", {31'd0, busy_o}, 32'd1);
        tx_busy_i = 1'b0;
        wait_idle("bz_idle");
        repeat (5) @(negedge clk);
        check("bz_ntx", tx_log.size() - base, 2);
        check("bz_resp", {16'd0, get_tx(base), get_tx(base + 1)}, 32'hCAFE);
        $display("read 00000008 with held busy => %h%h", get_tx(base), get_tx(base + 1));

        // Rules watched throughout the run
        check("tx_while_busy", busy_viol, 0);
        check("tx_back_to_back", gap_viol, 0);
        check("wb_ctl_rules", ctl_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wb_serial_master.md
WB_SERIAL_MASTER -- requirements
Module: wb_serial_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, is the Wishbone ack wait limit in clk_i cycles (range 2..65535).
REQ-002 clk_i  input  1  sole clock; all logic rising-edge.
REQ-003 rst_i  input  1  synchronous active-low reset.
REQ-004 rx_dat_i  input  8  received serial byte.
REQ-005 rx_stb_i  input  1  one-cycle strobe, rx_dat_i valid.
REQ-006 tx_dat_o  output  8  response byte.
REQ-007 tx_stb_o  output  1  one-cycle strobe, tx_dat_o valid.
REQ-008 tx_busy_i  input  1  transmitter busy; no tx_stb_o while high.
REQ-009 wb_adr_o  output  32  Wishbone byte address.
REQ-010 wb_dat_o / wb_dat_i  output/input  16  Wishbone write/read data.
REQ-011 wb_sel_o  output  2  byte selects.
REQ-012 wb_we_o, wb_cyc_o, wb_stb_o  output  1 each  Wishbone master controls.
REQ-013 wb_ack_i  input  1  slave acknowledge.
REQ-014 busy_o  output  1  high in every state except IDLE.

Function
REQ-015 The block SHALL be a Wishbone initiator driven by a byte command stream; commands: 0x57 'W' + 4 address bytes + 2 data bytes (both big-endian) = write; 0x52 'R' + 4 address bytes = read.
REQ-016 States SHALL be IDLE, ADDR, DATA, BUS, RESP; IDLE->ADDR on 'W'/'R', ADDR->DATA after 4th address byte for 'W', ADDR->BUS after 4th byte for 'R', DATA->BUS after 2nd data byte, BUS->RESP on ack or timeout, RESP->IDLE after final response byte sent.
REQ-017 Any other byte in IDLE SHALL produce response 0x3F '?' and stay logically in IDLE (via RESP).
REQ-018 wb_adr_o bit 0 SHALL be forced to 0; wb_sel_o SHALL be 2'b11 during every cycle.
REQ-019 On BUS entry wb_cyc_o and wb_stb_o SHALL assert the next cycle together, wb_we_o high for write, and remain high until the cycle where wb_ack_i is sampled high, deasserting the following cycle.
REQ-020 Read data SHALL be captured from wb_dat_i in the ack cycle.
REQ-021 Responses: write ok = 0x4B 'K'; read ok = data[15:8] then data[7:0]; timeout = 0x45 'E'.
REQ-022 tx_stb_o SHALL pulse only in a cycle with tx_busy_i low, and at most once per two cycles (gap allows transmitter to raise busy).
REQ-023 rx_stb_i in BUS or RESP SHALL be dropped without state change.
REQ-024 wb_ack_i outside an active cycle SHALL be ignored.
REQ-025 Address/data byte counter SHALL be 2 bits and wrap only on state exit.

Reset
REQ-026 rst_i low at a clock edge SHALL force IDLE, counters 0, and all outputs 0 (wb_adr_o, wb_dat_o, tx_dat_o zero), including mid-command and mid-Wishbone-cycle (cyc/stb drop next cycle).

Configuration
REQ-027 With WB_SERIAL_MASTER_TIMEOUT_EN defined, a 16-bit counter SHALL count BUS cycles with stb high and, on reaching TIMEOUT_CYCLES without ack, deassert cyc/stb and respond 'E'.
REQ-028 Without WB_SERIAL_MASTER_TIMEOUT_EN, BUS SHALL wait indefinitely for ack and 'E' SHALL never be sent.

Structure
REQ-029 Shared package SHALL hold the state encoding and command/response byte constants (0x57, 0x52, 0x4B, 0x45, 0x3F).
REQ-030 One sub-module, wb_serial_txq, SHALL sequence up to two response bytes against tx_busy_i.

Verification
REQ-031 Bytes 57 30 00 00 10 BE EF -> one write cycle adr 0x30000010, dat 0xBEEF, sel 11, we 1; after ack response 0x4B.
REQ-032 Bytes 52 10 00 00 02, slave acks with 0x1234 after 3 wait states -> response 0x12 then 0x34, cyc high exactly 4 cycles.
REQ-033 Byte 0x41 in IDLE -> response 0x3F, no Wishbone activity.
REQ-034 Read of 0xF0000021 with no ack, TIMEOUT_CYCLES=16, macro defined -> stb drops after 16 cycles, response 0x45, adr_o bit0 = 0.
REQ-035 rst_i low during BUS with stb high -> cyc/stb 0 next cycle, busy_o 0, no response byte; next command executes normally.
REQ-036 tx_busy_i held high 50 cycles during read response -> no tx_stb_o until busy low, both bytes then delivered in order.
